// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, default baud divisor and frame geometry.
package uart_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam int CLKS_PER_BIT_9600 = 10417;
  localparam int FRAME_BITS        = 10;
  localparam int DATA_BITS         = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..clks_per_bit-1 and wraps, pulsing bit_tick on the last count.
// Held at zero while clear is high so every bit period starts from a clean count.
module uart_baud_gen #(
  parameter int clks_per_bit = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  assign bit_tick = !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and serialises it as 8N1 on tx, LSB first.
// All outputs are registered; a new frame only starts from IDLE when tx_enable && !fifo_empty.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int clks_per_bit = CLKS_PER_BIT_9600,
  parameter int data_bits    = DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [data_bits-1:0] fifo_data,
  input  logic                 tx_enable,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int IDX_W = $clog2(data_bits);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_bits - 1);

  logic [2:0]           state_q, state_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 baud_clear;
  logic                 bit_tick;

  // The counter only runs while a bit is on the line, so START always begins at count 0.
  assign baud_clear = (state_q != START) && (state_q != DATA) && (state_q != STOP);

  uart_baud_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_done_d = 1'b0;
    case (state_q)
      IDLE:  if (tx_enable && !fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        state_d = START;
      end
      START: if (bit_tick) begin
        state_d   = DATA;
        bit_idx_d = '0;
      end
      DATA: if (bit_tick) begin
        if (bit_idx_q == LAST_IDX) begin
          state_d = STOP;
        end else begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: if (bit_tick) begin
        state_d   = IDLE;
        tx_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    fifo_read_d = (state_d == FETCH);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign fifo_read = fifo_read_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit FIFO. It pops one byte at a time through the FIFO read strobe and serialises it as an 8N1 UART frame on the BASYS3 USB-UART TX pin. The block sits between the FIFO read port and the board pin, and reports busy/done status to the top level.

Parameters:
clks_per_bit, 10417, clk cycles per UART bit (100 MHz / 9600 baud); minimum legal value is 2.
data_bits, 8, bits per frame; fixed at 8 to match the FIFO width.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high
fifo_empty  input  1  FIFO Empty flag
fifo_data  input  8  FIFO re_data; valid the cycle after a read strobe
tx_enable  input  1  when low, no new frame is started
fifo_read  output  1  single-cycle read strobe to the FIFO
tx  output  1  serial line; idles high
busy  output  1  high from FETCH through STOP
tx_done  output  1  one-cycle pulse at the end of the stop bit

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE, tx=1, fifo_read=0, busy=0, tx_done=0.
  - Baud counter=0, bit index=0, shift register=0.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If tx_enable && !fifo_empty, go to FETCH.
- FETCH (exactly 1 cycle):
  - fifo_read=1 for this cycle only; busy=1; then go to LOAD.
- LOAD (exactly 1 cycle):
  - fifo_data is valid here and is captured into the shift register at the closing edge.
  - Clear the baud counter; go to START.
- START: tx=0 for clks_per_bit cycles, then go to DATA with bit index=0.
- DATA:
  - tx = shift[0], LSB first.
  - Every clks_per_bit cycles, shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for clks_per_bit cycles.
  - At the final cycle, pulse tx_done=1 for 1 cycle and go to IDLE.
- Frame length: exactly 10*clks_per_bit cycles from the first tx low to the tx_done edge.
- Latency:
  - The first tx=0 appears 3 clk edges after IDLE observes !fifo_empty (IDLE -> FETCH -> LOAD -> START).
  - Back-to-back frames therefore have exactly 3 idle-high cycles between the stop bit and the next start bit.
- Baud counter:
  - Width is $clog2(clks_per_bit).
  - Counts 0..clks_per_bit-1 and wraps to 0 on each bit boundary; no drift or accumulation.
- fifo_read is never asserted while fifo_empty=1, so the block never causes FIFO underflow.
- fifo_read is never asserted more than once per frame.
- tx_enable deasserted mid-frame: the current frame completes normally; the block then stays in IDLE.
- fifo_empty rising mid-frame: no effect on the current frame.
- Reset mid-frame:
  - tx=1 on the next cycle and the frame is aborted.
  - No tx_done pulse; the popped byte is lost.
- fifo_empty deasserting in the same cycle STOP ends: the block sees it next cycle in IDLE.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE=0 … STOP=5, 3 bits.
  - Default CLKS_PER_BIT_9600=10417.
  - FRAME_BITS=10.
- One sub-module, uart_baud_gen:
  - Parameterised clks_per_bit counter with a clear input.
  - Emits a one-cycle bit_tick at count==clks_per_bit-1.
  - Reused later by the RX path.
- The FSM and shift register live in fifo_uart_tx.

Test Plan:
1. Run with clks_per_bit=4. FIFO model holds 0xA5, tx_enable=1.
   -> fifo_read high for exactly 1 cycle.
   -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total).
   -> tx_done pulses on cycle 40 after tx first goes low.
2. Queue 0x00 then 0xFF.
   -> Two frames with exactly 3 idle-high cycles between them.
   -> Exactly 2 fifo_read pulses; tx_done pulses twice.
3. Hold fifo_empty=1 for 100 cycles.
   -> fifo_read=0, tx=1, busy=0 throughout.
4. Drop tx_enable to 0 during DATA bit 3 of 0x3C with a second byte queued.
   -> The 0x3C frame completes with the correct bits.
   -> No further fifo_read; the block stays IDLE until tx_enable=1, then sends the second byte.
5. Assert reset for 1 cycle during DATA bit 5.
   -> tx=1 next cycle, busy=0, no tx_done.
   -> The next queued byte is sent as a clean full frame.
6. Run with clks_per_bit=10417, byte 0x55.
   -> Each bit period is exactly 10417 cycles.
   -> Frame lasts 104170 cycles, checked by scoreboard timestamps.
